sram22_bank_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of one sram22_4096x32m8w8 macro (cc_banks / mem style bank).
- After reset, zero-fills the whole array. Then grants at most one read or write per cycle, round-robin, and returns read data one cycle after acceptance.
- Sits between two client ports (e.g. refill path and core access path) and the macro pins.

---
 rtl/sram22_bank_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram22_bank_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_bank_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of one
// sram22_4096x32m8w8 macro. Zero-fills the array after reset, then grants
// at most one access per cycle and returns read data one cycle later.
module sram22_bank_arbiter #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MASK_W    = 4,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester 0
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [MASK_W-1:0] req0_wmask,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    // requester 1
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [MASK_W-1:0] req1_wmask,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    // macro pins
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_we,
    output logic [MASK_W-1:0] sram_wmask,
    input  logic [DATA_W-1:0] sram_dout,
    // status
    output logic              init_done
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_ptr;
    logic              r_resp0_valid;
    logic              r_resp1_valid;
    logic              w_gnt0;
    logic              w_gnt1;

    // State and fill-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, arbitration and macro drive; rst_n gating keeps the macro
    // quiet while reset is held even though the reset state is INIT.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        sram_we     = 1'b0;
        sram_wmask  = '0;
        sram_addr   = '0;
        sram_din    = '0;
        init_done   = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
                if (rst_n) begin
                    sram_we    = 1'b1;
                    sram_wmask = '1;
                    sram_addr  = r_cnt[ADDR_W-1:0];
                end
            end
            ST_RUN: begin
                init_done = rst_n;
                w_gnt0    = rst_n && req0_valid && (!req1_valid || !r_ptr);
                w_gnt1    = rst_n && req1_valid && (!req0_valid ||  r_ptr);
                if (w_gnt0) begin
                    sram_addr  = req0_addr;
                    sram_din   = req0_wdata;
                    sram_wmask = req0_wmask;
                    sram_we    = req0_we;
                end else if (w_gnt1) begin
                    sram_addr  = req1_addr;
                    sram_din   = req1_wdata;
                    sram_wmask = req1_wmask;
                    sram_we    = req1_we;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Round-robin pointer: after a grant, favour the other requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_ptr <= 1'b0;
        end
    end

    // Remember which requester owns the read data returning next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
        end else begin
            r_resp0_valid <= w_gnt0 && !req0_we;
            r_resp1_valid <= w_gnt1 && !req1_we;
        end
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp0_rdata = r_resp0_valid ? sram_dout : '0;
    assign resp1_rdata = r_resp1_valid ? sram_dout : '0;

endmodule

// File: tb/tb_sram22_bank_arbiter.sv
// Directed bench for sram22_bank_arbiter with a behavioural macro model.
module tb_sram22_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [11:0] req0_addr;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_wmask;
    logic        resp0_valid;
    logic [31:0] resp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [11:0] req1_addr;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_wmask;
    logic        resp1_valid;
    logic [31:0] resp1_rdata;
    logic [11:0] sram_addr;
    logic [31:0] sram_din;
    logic        sram_we;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_dout;
    logic        init_done;

    int vectors;
    int miscompares;

    sram22_bank_arbiter #(
        .ADDR_W(12), .DATA_W(32), .MASK_W(4), .INIT_ZERO(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we),
        .sram_wmask(sram_wmask), .sram_dout(sram_dout), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: byte-masked write, or registered read of the addressed word.
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    task automatic set_req0(input logic v, input logic we, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_wmask = m;
    endtask

    task automatic set_req1(input logic v, input logic we, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_wmask = m;
    endtask

    // Outputs while reset is held, with requests pending.
    task automatic test_reset();
        rst_n = 1'b0;
        set_req0(1'b1, 1'b0, 12'h000, 32'h0, 4'h0);
        set_req1(1'b1, 1'b1, 12'h001, 32'h1, 4'hF);
        #13;
        vectors++;
        if ({sram_we, sram_wmask, sram_addr, sram_din} !== 49'h0) begin
            miscompares++;
            $display("FAIL reset_macro: we=%b mask=%h addr=%h din=%h, want all 0",
                     sram_we, sram_wmask, sram_addr, sram_din);
        end
        vectors++;
        if ({init_done, req0_ready, req1_ready, resp0_valid, resp1_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_status: done/rdy0/rdy1/rv0/rv1=%b%b%b%b%b, want 00000",
                     init_done, req0_ready, req1_ready, resp0_valid, resp1_valid);
        end
        vectors++;
        if ({resp0_rdata, resp1_rdata} !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: %h %h, want 0 0", resp0_rdata, resp1_rdata);
        end
    endtask

    // Release reset and walk the full 4096-cycle zero fill.
    task automatic test_init_fill();
        int bad;
        bad = 0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req0(1'b1, 1'b0, 12'h000, 32'h0, 4'h0);
        set_req1(1'b1, 1'b0, 12'h000, 32'h0, 4'h0);
        for (int i = 0; i < 4096; i++) begin
            #1;
            if (sram_we !== 1'b1 || sram_addr !== 12'(i) || sram_din !== 32'h0 ||
                sram_wmask !== 4'hF || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
                init_done !== 1'b0) begin
                bad++;
            end
            @(negedge clk);
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL init_sequence: %0d bad fill cycles, want 0", bad);
        end
        #1;
        vectors++;
        if (init_done !== 1'b1) begin
            miscompares++;
            $display("FAIL init_done_rise: init_done=%b after 4096 cycles, want 1", init_done);
        end
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL first_grant: rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
        end
        set_req0(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        set_req1(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        @(negedge clk);
    endtask

    // Full-word write then read-back on the following cycle.
    task automatic test_write_read();
        set_req0(1'b1, 1'b1, 12'h123, 32'hDEADBEEF, 4'hF);
        #1;
        vectors++;
        if (req0_ready !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 12'h123 ||
            sram_din !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_drive: rdy=%b we=%b addr=%h din=%h, want 1 1 123 deadbeef",
                     req0_ready, sram_we, sram_addr, sram_din);
        end
        @(negedge clk);
        req0_we = 1'b0;
        #1;
        vectors++;
        if (req0_ready !== 1'b1 || sram_we !== 1'b0 || resp0_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_drive: rdy=%b we=%b rv0=%b, want 1 0 0",
                     req0_ready, sram_we, resp0_valid);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        vectors++;
        if (resp0_valid !== 1'b1 || resp0_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_resp: rv0=%b data=%h, want 1 deadbeef", resp0_valid, resp0_rdata);
        end
        vectors++;
        if (resp1_valid !== 1'b0 || resp1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rd_resp_other: rv1=%b data=%h, want 0 0", resp1_valid, resp1_rdata);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (resp0_valid !== 1'b0 || resp0_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rd_pulse: rv0=%b data=%h, want 0 0", resp0_valid, resp0_rdata);
        end
        @(negedge clk);
    endtask

    // Single-byte write into a zeroed word; unmasked bytes must stay zero.
    task automatic test_partial_write();
        set_req0(1'b1, 1'b1, 12'h010, 32'hFFFFABFF, 4'b0010);
        #1;
        vectors++;
        if (sram_wmask !== 4'b0010 || sram_we !== 1'b1) begin
            miscompares++;
            $display("FAIL pw_mask: mask=%b we=%b, want 0010 1", sram_wmask, sram_we);
        end
        @(negedge clk);
        req0_we = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        vectors++;
        if (resp0_valid !== 1'b1 || resp0_rdata !== 32'h0000AB00) begin
            miscompares++;
            $display("FAIL pw_read: rv0=%b data=%h, want 1 0000ab00", resp0_valid, resp0_rdata);
        end
        @(negedge clk);
    endtask

    // Both requesters reading continuously: grants alternate from req0.
    task automatic test_contention();
        int g;
        set_req1(1'b1, 1'b1, 12'h300, 32'hCAFE0001, 4'hF);
        #1;
        vectors++;
        if (req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_write1: rdy1=%b, want 1", req1_ready);
        end
        @(negedge clk);
        set_req0(1'b1, 1'b0, 12'h123, 32'h0, 4'h0);
        set_req1(1'b1, 1'b0, 12'h300, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            g = i % 2;
            #1;
            vectors++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                miscompares++;
                $display("FAIL alt_grant[%0d]: rdy0=%b rdy1=%b, want grant to req%0d",
                         i, req0_ready, req1_ready, g);
            end
            vectors++;
            if (i == 0) begin
                if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL alt_resp[0]: rv0=%b rv1=%b, want 0 0", resp0_valid, resp1_valid);
                end
            end else if (g == 1) begin
                if (resp0_valid !== 1'b1 || resp0_rdata !== 32'hDEADBEEF || resp1_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL alt_resp[%0d]: rv0=%b d0=%h rv1=%b, want 1 deadbeef 0",
                             i, resp0_valid, resp0_rdata, resp1_valid);
                end
            end else begin
                if (resp1_valid !== 1'b1 || resp1_rdata !== 32'hCAFE0001 || resp0_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL alt_resp[%0d]: rv1=%b d1=%h rv0=%b, want 1 cafe0001 0",
                             i, resp1_valid, resp1_rdata, resp0_valid);
                end
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        vectors++;
        if (resp1_valid !== 1'b1 || resp1_rdata !== 32'hCAFE0001 || resp0_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL alt_last: rv1=%b d1=%h rv0=%b, want 1 cafe0001 0",
                     resp1_valid, resp1_rdata, resp0_valid);
        end
        @(negedge clk);
    endtask

    // req1 alone streams without bubbles; next contention favours req0.
    task automatic test_back_to_back();
        set_req1(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: rdy1=%b rdy0=%b, want 1 0", i, req1_ready, req0_ready);
            end
            if (i > 0) begin
                vectors++;
                if (resp1_valid !== 1'b1 || resp1_rdata !== 32'h0000AB00) begin
                    miscompares++;
                    $display("FAIL b2b_resp[%0d]: rv1=%b d1=%h, want 1 0000ab00",
                             i, resp1_valid, resp1_rdata);
                end
            end
            @(negedge clk);
        end
        set_req0(1'b1, 1'b0, 12'h123, 32'h0, 4'h0);
        #1;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_next: rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        vectors++;
        if (resp0_valid !== 1'b1 || resp0_rdata !== 32'hDEADBEEF || resp1_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_last: rv0=%b d0=%h rv1=%b, want 1 deadbeef 0",
                     resp0_valid, resp0_rdata, resp1_valid);
        end
        @(negedge clk);
    endtask

    // Reset with a read in flight, then again mid-fill; fill restarts at 0.
    task automatic test_reset_mid();
        int bad;
        int seen;
        set_req0(1'b1, 1'b0, 12'h123, 32'h0, 4'h0);
        #1;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_grant: rdy0=%b, want 1", req0_ready);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (req0_ready !== 1'b0 || sram_we !== 1'b0 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_state: rdy0=%b we=%b done=%b, want 0 0 0",
                     req0_ready, sram_we, init_done);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_drop_resp: %0d response cycles seen, want 0", seen);
        end
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12'h800; i++) begin
            #1;
            if (sram_we !== 1'b1 || sram_addr !== 12'(i) || init_done !== 1'b0) bad++;
            @(negedge clk);
        end
        #1;
        vectors++;
        if (bad !== 0 || sram_addr !== 12'h800) begin
            miscompares++;
            $display("FAIL restart_fill: bad=%0d addr=%h, want 0 800", bad, sram_addr);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (sram_we !== 1'b0 || sram_addr !== 12'h000 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_init: we=%b addr=%h done=%b, want 0 000 0",
                     sram_we, sram_addr, init_done);
        end
        @(negedge clk);
        test_init_fill();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_init_fill();
        test_write_read();
        test_partial_write();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
